// File: rtl/xbee_msg_scheduler.sv
// xbee_msg_scheduler: round-robin grant of three Xbee status-message requesters
// (SI detector, supply pick, supply deposit), a small descriptor FIFO, and the
// tx_start/tx_complete sequencing toward the Xbee UART transmitter.
// Optional build macro: XBEE_SCHED_TIMEOUT_EN adds a SEND watchdog (timeout_err).
module xbee_msg_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned GAP_CYCLES  = 4340,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [23:0] req_desc,
  output logic [2:0]  ack,
  output logic        tx_start,
  output logic [1:0]  msg_type,
  output logic [1:0]  field,
  output logic [1:0]  node_si,
  output logic [1:0]  color,
  input  logic        tx_complete,
  output logic        busy,
  output logic        fifo_full,
  output logic        bad_msg,
  output logic        timeout_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [1:0]         rr_q, rr_d;
  logic [2:0]         ack_q, ack_d;
  logic               bad_q, bad_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         desc_q, desc_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               busy_q, busy_d;
  logic               full_q, full_d;
  logic [7:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               grant_ok, grant_vld, desc_ok, push, pop, timeout_hit;
  logic [1:0]         grant_idx, cand_idx;
  logic [7:0]         desc_sel;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  assign pop      = (state_q == S_LOAD);
  assign grant_ok = (count_q != CNT_W'(DEPTH)) || pop;

  // Round-robin search starting at rr_q; a full FIFO blocks grants unless the head is popped now.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand_idx  = 2'd0;
    for (int k = 0; k < 3; k++) begin
      cand_idx = wrap3({1'b0, rr_q} + 3'(k));
      if (!grant_vld && grant_ok && req[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Descriptor of the granted requester and its validity.
  always_comb begin
    case (grant_idx)
      2'd1:    desc_sel = req_desc[15:8];
      2'd2:    desc_sel = req_desc[23:16];
      default: desc_sel = req_desc[7:0];
    endcase
  end

  assign desc_ok = (desc_sel[7:6] != 2'd0) && (desc_sel[3:2] != 2'd0) && (desc_sel[1:0] != 2'd0);
  assign push    = grant_vld && desc_ok;

  // Grant-side next values: ack pulse, reject pulse, pointer advance, occupancy.
  always_comb begin
    ack_d   = grant_vld ? (3'b001 << grant_idx) : 3'b000;
    bad_d   = grant_vld && !desc_ok;
    rr_d    = grant_vld ? wrap3({1'b0, grant_idx} + 3'd1) : rr_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

`ifdef XBEE_SCHED_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  logic [31:0] to_cnt_q;
  logic        timeout_err_q;

  assign timeout_hit = (to_cnt_q == TO_LAST);
  assign timeout_err = timeout_err_q;

  // Watchdog counts cycles spent in SEND; the error flag is sticky until reset.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q      <= 32'd0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == S_SEND) ? to_cnt_q + 32'd1 : 32'd0;
      if ((state_q == S_SEND) && !tx_complete && timeout_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end
`else
  // The watchdog limit only matters when the watchdog is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  // Transmit sequencing: next state plus registered handshake/descriptor outputs.
  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    desc_d     = desc_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        desc_d     = mem_q[rd_ptr_q];
        tx_start_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tx_complete || timeout_hit) begin
          tx_start_d = 1'b0;
          gap_cnt_d  = GAP_W'(GAP_CYCLES);
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  // FSM state register.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 2'd0;
      ack_q      <= 3'b000;
      bad_q      <= 1'b0;
      tx_start_q <= 1'b0;
      desc_q     <= 8'd0;
      gap_cnt_q  <= '0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      rr_q       <= rr_d;
      ack_q      <= ack_d;
      bad_q      <= bad_d;
      tx_start_q <= tx_start_d;
      desc_q     <= desc_d;
      gap_cnt_q  <= gap_cnt_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
      count_q    <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= desc_sel;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign ack       = ack_q;
  assign bad_msg   = bad_q;
  assign tx_start  = tx_start_q;
  assign msg_type  = desc_q[7:6];
  assign field     = desc_q[5:4];
  assign node_si   = desc_q[3:2];
  assign color     = desc_q[1:0];
  assign busy      = busy_q;
  assign fifo_full = full_q;

endmodule

// File: tb/tb_xbee_msg_scheduler.sv
// Self-checking bench for xbee_msg_scheduler: a queue-based behavioural model is
// stepped once per clock and every output is compared after each rising edge.
// Define XBEE_SCHED_TIMEOUT_EN for both files to exercise the watchdog build.
module tb_xbee_msg_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 6;
  localparam int unsigned TOUT  = 40;

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_SEND = 2;
  localparam int PH_GAP  = 3;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] req_desc;
  logic [2:0]  ack;
  logic        tx_start;
  logic [1:0]  msg_type, field, node_si, color;
  logic        tx_complete;
  logic        busy, fifo_full, bad_msg, timeout_err;

  xbee_msg_scheduler #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .req        (req),
    .req_desc   (req_desc),
    .ack        (ack),
    .tx_start   (tx_start),
    .msg_type   (msg_type),
    .field      (field),
    .node_si    (node_si),
    .color      (color),
    .tx_complete(tx_complete),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .bad_msg    (bad_msg),
    .timeout_err(timeout_err)
  );

  always #10 clk_50M = ~clk_50M;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0] m_q[$];
  logic [7:0] m_log[$];
  int         m_ph;
  int         m_rr;
  logic [7:0] m_cur;
  int         m_gap_done;
  int         m_send_len;
  bit         m_terr;
  logic [2:0] m_ack;
  bit         m_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ph       = PH_IDLE;
    m_rr       = 0;
    m_cur      = 8'd0;
    m_gap_done = 0;
    m_send_len = 0;
    m_terr     = 1'b0;
    m_ack      = 3'b000;
    m_bad      = 1'b0;
  endtask

  // One clock of the scheduler as described: grant, validate, sequence, enqueue.
  task automatic model_step();
    int g, i, pre;
    logic [7:0] dd;
    bit ok, can;
    g  = -1;
    ok = 1'b0;
    dd = 8'd0;
    can = (m_q.size() < DEPTH) || (m_ph == PH_LOAD);
    if (can) begin
      for (int k = 0; k < 3; k++) begin
        i = (m_rr + k) % 3;
        if (g < 0 && req[i]) g = i;
      end
    end
    m_ack = 3'b000;
    m_bad = 1'b0;
    if (g >= 0) begin
      m_ack[g] = 1'b1;
      m_rr     = (g + 1) % 3;
      dd       = req_desc[8*g +: 8];
      ok       = (dd[7:6] != 2'd0) && (dd[3:2] != 2'd0) && (dd[1:0] != 2'd0);
      m_bad    = !ok;
    end
    pre = m_q.size();
    case (m_ph)
      PH_IDLE: if (pre > 0) m_ph = PH_LOAD;
      PH_LOAD: begin
        m_cur = m_q.pop_front();
        m_log.push_back(m_cur);
        m_ph       = PH_SEND;
        m_send_len = 0;
      end
      PH_SEND: begin
        if (tx_complete) begin
          m_ph       = PH_GAP;
          m_gap_done = 0;
        end
`ifdef XBEE_SCHED_TIMEOUT_EN
        else if (m_send_len + 1 >= int'(TOUT)) begin
          m_ph       = PH_GAP;
          m_gap_done = 0;
          m_terr     = 1'b1;
        end
`endif
        else m_send_len++;
      end
      PH_GAP: begin
        m_gap_done++;
        if (m_gap_done >= ((GAP > 0) ? int'(GAP) : 1)) m_ph = PH_IDLE;
      end
      default: m_ph = PH_IDLE;
    endcase
    if (g >= 0 && ok) m_q.push_back(dd);
  endtask

  task automatic compare_all();
    chk("ack",         32'(ack),         32'(m_ack));
    chk("bad_msg",     32'(bad_msg),     32'(m_bad));
    chk("tx_start",    32'(tx_start),    32'(m_ph == PH_SEND));
    chk("msg_type",    32'(msg_type),    32'(m_cur[7:6]));
    chk("field",       32'(field),       32'(m_cur[5:4]));
    chk("node_si",     32'(node_si),     32'(m_cur[3:2]));
    chk("color",       32'(color),       32'(m_cur[1:0]));
    chk("fifo_full",   32'(fifo_full),   32'(m_q.size() == DEPTH));
    chk("busy",        32'(busy),        32'((m_ph != PH_IDLE) || (m_q.size() != 0)));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  // Advance one clock: step the model, then compare just after the edge; requesters drop on ack.
  task automatic tick();
    model_step();
    @(posedge clk_50M);
    #1;
    compare_all();
    req = req & ~m_ack;
  endtask

  task automatic pulse_txc();
    tx_complete = 1'b1;
    tick();
    tx_complete = 1'b0;
  endtask

  task automatic send_req(input int idx, input logic [7:0] d, output logic [2:0] got);
    int n;
    req_desc[8*idx +: 8] = d;
    req[idx] = 1'b1;
    got = 3'b000;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (m_ack[idx]) begin
        got = ack;
        break;
      end
    end
    chk("ack_seen", 32'(ack[idx]), 32'd1);
    req[idx] = 1'b0;
  endtask

  task automatic wait_send();
    int n;
    n = 0;
    while (n < 50 && m_ph != PH_SEND) begin
      tick();
      n++;
    end
    chk("tx_start_up", 32'(tx_start), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 3000 && !(m_ph == PH_IDLE && m_q.size() == 0)) begin
      if (m_ph == PH_SEND && m_send_len >= 2) pulse_txc();
      else tick();
      n++;
    end
    chk("drained_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [2:0] got;
    logic [2:0] a [3];
    int low, n;

    rst_n = 1'b0;
    req = 3'b000;
    req_desc = 24'd0;
    tx_complete = 1'b0;
    model_reset();
    #15;
    chk("rst_ack",       32'(ack),         32'd0);
    chk("rst_tx_start",  32'(tx_start),    32'd0);
    chk("rst_busy",      32'(busy),        32'd0);
    chk("rst_fifo_full", 32'(fifo_full),   32'd0);
    chk("rst_bad_msg",   32'(bad_msg),     32'd0);
    chk("rst_msg_type",  32'(msg_type),    32'd0);
    chk("rst_timeout",   32'(timeout_err), 32'd0);
    @(negedge clk_50M);
    rst_n = 1'b1;

    // 1: single request, latency and descriptor fields
    req_desc[7:0] = 8'h9F;
    req = 3'b001;
    tick();
    chk("t1_ack", 32'(ack), 32'b001);
    tick();
    chk("t1_tx_early", 32'(tx_start), 32'd0);
    tick();
    chk("t1_tx", 32'(tx_start), 32'd1);
    chk("t1_msg_type", 32'(msg_type), 32'd2);
    chk("t1_field", 32'(field), 32'd1);
    chk("t1_node", 32'(node_si), 32'd3);
    chk("t1_color", 32'(color), 32'd3);
    repeat (3) tick();
    // 5: completion drops tx_start; gap holds it low, tx_complete in GAP ignored
    pulse_txc();
    chk("t5_tx_drop", 32'(tx_start), 32'd0);
    for (int i = 0; i < int'(GAP); i++) begin
      tx_complete = (i == 2);
      tick();
      chk("t5_gap_low", 32'(tx_start), 32'd0);
    end
    tx_complete = 1'b0;
    drain();

    // 4: invalid descriptors (node 0, type 0, color 0) are acked and dropped
    send_req(0, 8'h41, got);
    chk("t4_ack_node0", 32'(got), 32'b001);
    chk("t4_bad_node0", 32'(bad_msg), 32'd1);
    tick();
    chk("t4_bad_clear", 32'(bad_msg), 32'd0);
    send_req(1, 8'h05, got);
    chk("t4_bad_type0", 32'(bad_msg), 32'd1);
    send_req(2, 8'h44, got);
    chk("t4_bad_color0", 32'(bad_msg), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_no_tx", 32'(tx_start), 32'd0);
    end
    chk("t4_not_busy", 32'(busy), 32'd0);

    // 2: simultaneous requests granted round-robin, sent in grant order
    m_log.delete();
    req_desc = {8'hFF, 8'h9A, 8'h45};
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      a[i] = ack;
    end
    chk("t2_ack0", 32'(a[0]), 32'b001);
    chk("t2_ack1", 32'(a[1]), 32'b010);
    chk("t2_ack2", 32'(a[2]), 32'b100);
    tick();
    tick();
    pulse_txc();
    low = 1;
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (m_ph == PH_SEND) break;
      low++;
    end
    chk("t2_gap_len", 32'(low), 32'(GAP + 2));
    chk("t2_second_tx", 32'(tx_start), 32'd1);
    drain();
    chk("t2_order0", 32'(m_log[0]), 32'h45);
    chk("t2_order1", 32'(m_log[1]), 32'h9A);
    chk("t2_order2", 32'(m_log[2]), 32'hFF);

    // 3: fill FIFO while SEND holds; blocked request granted on the pop cycle
    send_req(0, 8'h45, got);
    wait_send();
    send_req(1, 8'h9A, got);
    send_req(2, 8'hFF, got);
    send_req(0, 8'hD6, got);
    send_req(1, 8'h6B, got);
    chk("t3_full", 32'(fifo_full), 32'd1);
    req_desc[23:16] = 8'hE7;
    req[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_no_ack", 32'(ack), 32'd0);
    end
    pulse_txc();
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (m_ack[2]) break;
    end
    chk("t3_ack_on_pop", 32'(ack), 32'b100);
    chk("t3_tx_at_pop", 32'(tx_start), 32'd1);
    chk("t3_full_kept", 32'(fifo_full), 32'd1);
    req[2] = 1'b0;
    drain();

    // tx_complete while idle is ignored
    tx_complete = 1'b1;
    repeat (3) tick();
    tx_complete = 1'b0;
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // 6: asynchronous reset in the middle of a transmission
    send_req(1, 8'h9A, got);
    wait_send();
    send_req(2, 8'hFF, got);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tx", 32'(tx_start), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_full", 32'(fifo_full), 32'd0);
    chk("t6_rst_msg", 32'(msg_type), 32'd0);
    req = 3'b000;
    model_reset();
    @(negedge clk_50M);
    rst_n = 1'b1;
    req_desc = {8'hE7, 8'h9A, 8'h45};
    req = 3'b110;
    tick();
    chk("t6_rr_reset", 32'(ack), 32'b010);
    tick();
    chk("t6_rotate", 32'(ack), 32'b100);
    drain();

`ifdef XBEE_SCHED_TIMEOUT_EN
    send_req(0, 8'h45, got);
    wait_send();
    n = 0;
    while (n < int'(TOUT) + 20 && !m_terr) begin
      tick();
      n++;
    end
    chk("t6_timeout_err", 32'(timeout_err), 32'd1);
    chk("t6_timeout_tx", 32'(tx_start), 32'd0);
    drain();
    chk("t6_timeout_sticky", 32'(timeout_err), 32'd1);
`else
    send_req(0, 8'h45, got);
    wait_send();
    repeat (100) tick();
    chk("t6_send_holds", 32'(tx_start), 32'd1);
    chk("t6_no_timeout", 32'(timeout_err), 32'd0);
    pulse_txc();
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
